seqmul: RTL and testbench



---
 rtl/seqmul_pkg.sv | 23 ++
 rtl/seqmul_if.sv | 28 ++
 rtl/seqmul.sv | 118 +++++++++++
 tb/tb_seqmul.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/seqmul_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
package seqmul_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_t;

  typedef logic [1:0] mul_state_t;
  localparam mul_state_t IDLE = 2'd0;
  localparam mul_state_t RUN  = 2'd1;
  localparam mul_state_t DONE = 2'd2;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_CNT_W = $clog2(MUL_WIDTH);

  function automatic int mul_cnt_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/seqmul_if.sv
// Request/response bundle between the execute stage and the multiplier.
interface seqmul_if #(parameter int WIDTH = 32);
  import seqmul_pkg::*;

  // start is taken only in a cycle where busy=0; otherwise it is dropped.
  // done pulses for one cycle and result/flag are valid in that cycle,
  // then held until the next accepted start.
  logic             start;
  mul_op_t          op;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [1:0]       flag;
  mul_state_t       dbg_state;

  modport master (
    output start, op, multiplicand, multiplier, flush,
    input  busy, done, result, flag, dbg_state
  );

  modport slave (
    input  start, op, multiplicand, multiplier, flush,
    output busy, done, result, flag, dbg_state
  );
endinterface

// File: rtl/seqmul.sv
// Radix-2 shift-add multiplier: WIDTH iterations on magnitudes, sign fixed
// up on the final iteration, result word selected by op.
module seqmul
  import seqmul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      rst,
  seqmul_if.slave  bus
);

  localparam int CNT_W = mul_cnt_w(WIDTH);

  mul_state_t       state;
  mul_op_t          op_q;
  logic             neg_q;
  logic [WIDTH:0]   mcand_q;
  logic [WIDTH:0]   acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] result_q;
  logic [1:0]       flag_q;

  function automatic logic a_signed(input mul_op_t o);
    return o != MULHU;
  endfunction

  function automatic logic b_signed(input mul_op_t o);
    return (o == MUL) || (o == MULH);
  endfunction

  // Extra bit keeps the most-negative operand representable as a magnitude.
  function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return {1'b0, (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v};
  endfunction

  logic [WIDTH:0]     a_mag;
  logic [WIDTH:0]     b_mag;
  logic               start_neg;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     hi_nxt;
  logic [WIDTH-1:0]   lo_nxt;
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH:0]     prod_top;
  logic [WIDTH-1:0]   res_sel;
  logic               ovf;

  always_comb begin
    a_mag     = magnitude(bus.multiplicand, a_signed(bus.op));
    b_mag     = magnitude(bus.multiplier, b_signed(bus.op));
    start_neg = (a_signed(bus.op) & bus.multiplicand[WIDTH-1])
              ^ (b_signed(bus.op) & bus.multiplier[WIDTH-1]);

    sum      = acc_hi + (acc_lo[0] ? mcand_q : '0);
    hi_nxt   = {1'b0, sum[WIDTH:1]};
    lo_nxt   = {sum[0], acc_lo[WIDTH-1:1]};
    prod_mag = {hi_nxt[WIDTH-1:0], lo_nxt};
    product  = neg_q ? (~prod_mag + 1'b1) : prod_mag;

    // MUL overflows when the upper half is not a sign extension of the low word.
    prod_top = product[2*WIDTH-1:WIDTH-1];
    ovf      = !((&prod_top) || (~|prod_top));
    res_sel  = (op_q == MUL) ? product[WIDTH-1:0] : product[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= MUL;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      count    <= '0;
      result_q <= '0;
      flag_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q    <= bus.op;
            neg_q   <= start_neg;
            mcand_q <= a_mag;
            acc_hi  <= '0;
            acc_lo  <= b_mag[WIDTH-1:0];
            count   <= CNT_W'(WIDTH - 1);
            state   <= RUN;
          end
        end
        RUN: begin
          if (bus.flush) begin
            state <= IDLE;
          end else begin
            acc_hi <= hi_nxt;
            acc_lo <= lo_nxt;
            count  <= count - CNT_W'(1);
            if (count == '0) begin
              result_q <= res_sel;
              flag_q   <= {(op_q == MUL) && ovf, res_sel == '0};
              state    <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.result    = result_q;
  assign bus.flag      = flag_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_seqmul.sv
// Directed bench for seqmul: driver tasks push expected {flag,result} and done
// cycle into a scoreboard; a monitor pops and compares on every done pulse.
module tb_seqmul;
  import seqmul_pkg::*;

  localparam int W = 32;

  logic clk;
  logic rst;
  int   cyc;

  seqmul_if #(.WIDTH(W)) bus ();

  seqmul #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [W+1:0] exp_q[$];
  int           exp_cyc_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] prev_res;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        logic [W+1:0] e;
        int           ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("done_flag_result", {30'd0, bus.flag, bus.result}, {30'd0, e});
        check("done_cycle", 64'(cyc), 64'(ec));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called right after a negedge while busy=0; returns at the next negedge.
  task automatic issue(input mul_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] res, input logic [1:0] flg);
    bus.start        = 1'b1;
    bus.op           = op;
    bus.multiplicand = a;
    bus.multiplier   = b;
    exp_q.push_back({flg, res});
    exp_cyc_q.push_back(cyc + W + 1);
    @(negedge clk);
    bus.start        = 1'b0;
    bus.multiplicand = $urandom();
    bus.multiplier   = $urandom();
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) check({name, "_timeout"}, 64'(bus.busy), 64'd0);
  endtask

  typedef struct {
    mul_op_t      op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [1:0]   flg;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2'b00};
    vecs[1]  = '{MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2'b01};
    vecs[2]  = '{MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 2'b00};
    vecs[3]  = '{MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 2'b00};
    vecs[4]  = '{MUL,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2'b10};
    vecs[5]  = '{MULH,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2'b01};
    vecs[6]  = '{MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2'b00};
    vecs[7]  = '{MUL,    32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 2'b11};
    vecs[8]  = '{MULHU,  32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 2'b00};
    vecs[9]  = '{MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2'b00};
    vecs[10] = '{MUL,    32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1, 2'b00};
    vecs[11] = '{MULHU,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 2'b00};
  end

  // ---------------- stimulus ----------------
  initial begin
    logic busy_bad;
    int   n;

    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.flush        = 1'b0;
    bus.op           = MUL;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("reset_busy",   64'(bus.busy),   64'd0);
    check("reset_done",   64'(bus.done),   64'd0);
    check("reset_result", 64'(bus.result), 64'd0);
    check("reset_flag",   64'(bus.flag),   64'd0);

    // 7*6: busy throughout cycles 1..33, idle in 34.
    issue(MUL, 32'd7, 32'd6, 32'h0000_002A, 2'b00);
    busy_bad = 1'b0;
    for (int i = 0; i < W + 1; i++) begin
      if (!bus.busy) busy_bad = 1'b1;
      @(negedge clk);
    end
    check("busy_window", 64'(busy_bad), 64'd0);
    check("busy_after_done", 64'(bus.busy), 64'd0);
    prev_res = 32'h0000_002A;

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flg);
      wait_idle("vec");
      prev_res = vecs[i].res;
    end

    // Start while busy is dropped; next start in the cycle after done is taken.
    issue(MUL, 32'd100, 32'd3, 32'd300, 2'b00);
    repeat (4) @(negedge clk);
    bus.start        = 1'b1;
    bus.op           = MULHU;
    bus.multiplicand = 32'd11;
    bus.multiplier   = 32'd13;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ignored_start_done_seen", 64'(bus.done), 64'd1);
    check("ignored_start_result", 64'(bus.result), 64'd300);
    @(negedge clk);
    check("idle_after_done", 64'(bus.busy), 64'd0);
    issue(MULH, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 2'b00);
    wait_idle("back_to_back");
    prev_res = 32'hFFFF_FFFF;

    // Flush in cycle 10 of a run: idle next cycle, result held, no done.
    issue(MUL, 32'd9, 32'd9, 32'd81, 2'b00);
    void'(exp_q.pop_back());
    void'(exp_cyc_q.pop_back());
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", 64'(bus.busy), 64'd0);
    check("flush_done", 64'(bus.done), 64'd0);
    check("flush_result_held", 64'(bus.result), 64'(prev_res));
    issue(MULHU, 32'h1234_0000, 32'h0001_0000, 32'h0000_1234, 2'b00);
    wait_idle("after_flush");
    prev_res = 32'h0000_1234;

    // Synchronous reset in cycle 20 of a run clears everything.
    issue(MUL, 32'd5, 32'd5, 32'd25, 2'b00);
    void'(exp_q.pop_back());
    void'(exp_cyc_q.pop_back());
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_busy",   64'(bus.busy),   64'd0);
    check("rst_mid_done",   64'(bus.done),   64'd0);
    check("rst_mid_result", 64'(bus.result), 64'd0);
    check("rst_mid_flag",   64'(bus.flag),   64'd0);
    rst = 1'b0;
    @(negedge clk);
    issue(MUL, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 32'h0000_002A, 2'b00);
    wait_idle("after_rst");

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
